// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Walks a 4-input combinational function through all 16 input rows, holds
// each row for SETTLE cycles so the function output can settle, samples the
// function output once per row, and compares the captured truth table with
// a golden table.
//
// Parameters
//   SETTLE      cycles each row is held before it is sampled (1..15)
//
// Ports
//   clk         single clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start       request a full 16-row sweep (ignored while busy)
//   s_in        output of the function under test
//   expected    golden truth table, bit i = expected output for row i
//   x, y, w, z  stimulus into the function, x is MSB, z is LSB
//   busy        sweep in progress
//   done        sweep complete, result outputs valid
//   table_out   captured truth table, bit i = s_in sampled for row i
//   mismatch    table_out differs from expected
//   fail_index  lowest row where table_out and expected differ (0 if none)
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_in,
    input  logic [15:0] expected,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        mismatch,
    output logic [3:0]  fail_index
);

    // Four bits covers every legal SETTLE; the counter only ever reaches
    // SETTLE-1 before handing over to SAMPLE.
    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       idx;
    logic [3:0]       idx_next;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_cnt_next;
    logic [15:0]      table_next;
    logic             mismatch_next;
    logic [3:0]       fail_index_next;

    logic [15:0]      final_table;
    logic [15:0]      diff;
    logic [3:0]       lowest_diff;

    // Result of the current SAMPLE cycle: the stored table with the bit for
    // the current row replaced by s_in. At the row-15 sample this is the
    // complete table, so the comparison against expected can be formed in
    // the same cycle and registered on DONE entry. Scanning from the top
    // down lets the lowest differing row win.
    always_comb begin
        final_table      = table_out;
        final_table[idx] = s_in;
        diff             = final_table ^ expected;
        lowest_diff      = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                lowest_diff = 4'(i);
            end
        end
    end

    // Next-state and datapath update logic. Everything holds by default;
    // a start from IDLE or DONE clears the results and launches row 0,
    // DRIVE counts out the settle time, and SAMPLE captures one row and
    // either advances to the next row or finishes the sweep. start is not
    // looked at in DRIVE or SAMPLE, so a start during a sweep is ignored.
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        settle_cnt_next = settle_cnt;
        table_next      = table_out;
        mismatch_next   = mismatch;
        fail_index_next = fail_index;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next      = DRIVE;
                    idx_next        = 4'd0;
                    settle_cnt_next = '0;
                    table_next      = 16'h0000;
                    mismatch_next   = 1'b0;
                    fail_index_next = 4'd0;
                end
            end

            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next      = SAMPLE;
                    settle_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt + CNT_W'(1);
                end
            end

            SAMPLE: begin
                table_next = final_table;
                if (idx == 4'd15) begin
                    state_next      = DONE;
                    mismatch_next   = |diff;
                    fail_index_next = lowest_diff;
                end else begin
                    state_next = DRIVE;
                    idx_next   = idx + 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset drops straight back to IDLE, which aborts any
    // sweep in progress; a new start is needed afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Row index, settle counter and result registers. Reset discards any
    // partial table so nothing from an aborted sweep is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            settle_cnt <= '0;
            table_out  <= 16'h0000;
            mismatch   <= 1'b0;
            fail_index <= 4'd0;
        end else begin
            idx        <= idx_next;
            settle_cnt <= settle_cnt_next;
            table_out  <= table_next;
            mismatch   <= mismatch_next;
            fail_index <= fail_index_next;
        end
    end

    // Status and stimulus outputs decode directly from registered state, so
    // they follow reset immediately. Outside a sweep the function inputs
    // are parked at row 0.
    assign busy         = (state == DRIVE) || (state == SAMPLE);
    assign done         = (state == DONE);
    assign {x, y, w, z} = busy ? idx : 4'b0000;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles each input row is held before its output is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a full 16-row sweep; sampled on the rising edge.
REQ-005 Port: s_in  input  1  output of the downstream 4-input combinational function under test.
REQ-006 Port: expected  input  16  golden truth table; bit i is the expected output for row i.
REQ-007 Ports: x, y, w, z  output  1 each  stimulus driven into the 4-input function; x is MSB, z is LSB.
REQ-008 Port: busy  output  1  sweep in progress.
REQ-009 Port: done  output  1  sweep complete; result outputs valid.
REQ-010 Port: table_out  output  16  captured truth table; bit i is s_in sampled for row i.
REQ-011 Port: mismatch  output  1  table_out differs from expected.
REQ-012 Port: fail_index  output  4  lowest row index where table_out and expected differ.

Function
REQ-013 The block SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE, held in registers.
REQ-014 The block SHALL hold a 4-bit row index idx and a settle counter wide enough for SETTLE.
REQ-015 In IDLE or DONE with start=1, the block SHALL clear table_out, mismatch, fail_index and done, set idx=0, and enter DRIVE on that edge.
REQ-016 In DRIVE and SAMPLE, the block SHALL drive {x,y,w,z}=idx; in IDLE and DONE it SHALL drive {x,y,w,z}=4'b0000.
REQ-017 DRIVE SHALL last exactly SETTLE cycles, then transition to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; on its closing edge the block SHALL write s_in into table_out[idx].
REQ-019 On that same edge, if idx<15 the block SHALL increment idx and return to DRIVE; if idx=15 it SHALL enter DONE.
REQ-020 Row i SHALL be captured 2+i*(SETTLE+1)+(SETTLE-1) edges after the accepting edge; done SHALL rise exactly 16*(SETTLE+1) edges after the accepting edge.
REQ-021 On entry to DONE, mismatch SHALL equal OR(table_out XOR expected), computed with the row-15 bit just captured.
REQ-022 On entry to DONE, fail_index SHALL be the lowest differing bit position, or 0 when mismatch=0.
REQ-023 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-024 done SHALL be 1 exactly in DONE and SHALL remain high, with table_out, mismatch and fail_index stable, until the next accepted start or reset.
REQ-025 start asserted while busy=1 SHALL be ignored, with no effect on idx, timing or results.
REQ-026 start held high continuously SHALL relaunch a sweep on the first edge in DONE, and done SHALL then be high for exactly one cycle.
REQ-027 expected SHALL be sampled only at DONE entry; changes during a sweep SHALL have no effect.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force:
- state=IDLE, idx=0, settle counter=0;
- x=y=w=z=0;
- busy=0, done=0;
- table_out=16'h0000, mismatch=0, fail_index=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep, discard partial results, and require a new start after release.
REQ-030 The first rising edge after rst_n deasserts SHALL behave as a normal IDLE edge.

Verification
REQ-031 DUT driving a PoS function with zeros at rows 0,1,6,7,8,9,12,14, SETTLE=1, expected=16'hAC3C, one-cycle start -> done rises 32 edges later; table_out=16'hAC3C, mismatch=0, fail_index=0.
REQ-032 Same function, expected=16'hAC3D -> mismatch=1, fail_index=0; expected=16'h2C3C -> mismatch=1, fail_index=15.
REQ-033 SETTLE=3, s_in tied to x -> done 64 edges after start; table_out=16'hFF00; {x,y,w,z} holds each row 4 cycles in order 0..15.
REQ-034 rst_n pulsed low during row 7 -> busy, done and outputs read 0 immediately; no done without a new start; a fresh sweep then yields correct results.
REQ-035 start pulsed again at row 5 -> ignored, done still at edge 32; start held high -> back-to-back sweeps, done high one cycle each.
